// File: rtl/debouncer_multi_if.sv
// Button bundle: raw pins toward the conditioner, debounced levels and pulses back.
// The master side is the conditioner that drives the conditioned outputs.
interface debouncer_multi_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] btn_raw;
   logic [CHANNELS-1:0] stable;
   logic [CHANNELS-1:0] pressed;
   logic [CHANNELS-1:0] released;
   logic [CHANNELS-1:0] long_press;
   logic [CHANNELS-1:0] repeat_pulse;
   logic                any_pressed;

   modport master (
      input  btn_raw,
      output stable, pressed, released, long_press, repeat_pulse, any_pressed
   );

   modport slave (
      output btn_raw,
      input  stable, pressed, released, long_press, repeat_pulse, any_pressed
   );
endinterface

// File: rtl/debouncer_multi.sv
// N-channel button conditioner: 2-flop sync, debounce, press/release/long-press/repeat pulses.
// Pin edge to stable/pulse takes 2+DEBOUNCE_CYCLES cycles; free-running, no backpressure.
module debouncer_multi #(
   parameter int CHANNELS        = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int CNT_WIDTH       = 4,
   parameter int HOLD_CYCLES     = 100,
   parameter int REPEAT_CYCLES   = 20,
   parameter int HOLD_WIDTH      = 16
) (
   input  logic              clk,
   input  logic              rst,
   debouncer_multi_if.master bus
);
   localparam logic [CHANNELS-1:0]   IDLE_PIN  = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [HOLD_WIDTH-1:0] HOLD_DONE = HOLD_WIDTH'(HOLD_CYCLES);
   localparam logic [HOLD_WIDTH-1:0] REP_LAST  =
      HOLD_WIDTH'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

   logic [CHANNELS-1:0]   sync1_q, sync1_d;
   logic [CHANNELS-1:0]   sync2_q, sync2_d;
   logic [CHANNELS-1:0]   stable_q, stable_d;
   logic [CHANNELS-1:0]   pressed_q, pressed_d;
   logic [CHANNELS-1:0]   released_q, released_d;
   logic [CHANNELS-1:0]   long_press_q, long_press_d;
   logic [CHANNELS-1:0]   repeat_pulse_q, repeat_pulse_d;
   logic                  any_pressed_q, any_pressed_d;
   logic [CNT_WIDTH-1:0]  cnt_q  [CHANNELS];
   logic [CNT_WIDTH-1:0]  cnt_d  [CHANNELS];
   logic [HOLD_WIDTH-1:0] hold_q [CHANNELS];
   logic [HOLD_WIDTH-1:0] hold_d [CHANNELS];
   logic [HOLD_WIDTH-1:0] rep_q  [CHANNELS];
   logic [HOLD_WIDTH-1:0] rep_d  [CHANNELS];
   logic [CHANNELS-1:0]   btn_s;

   // btn_s is 1 when the channel is pressed, whatever the pin polarity.
   assign btn_s = sync2_q ^ IDLE_PIN;

   always_comb begin
      sync1_d        = bus.btn_raw;
      sync2_d        = sync1_q;
      stable_d       = stable_q;
      pressed_d      = '0;
      released_d     = '0;
      long_press_d   = '0;
      repeat_pulse_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i]  = '0;
         hold_d[i] = hold_q[i];
         rep_d[i]  = rep_q[i];
         if (btn_s[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i]   = btn_s[i];
               pressed_d[i]  = btn_s[i];
               released_d[i] = ~btn_s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         // A committing release wins over any hold/repeat event due in the same cycle.
         if (pressed_d[i] || released_d[i] || !stable_q[i]) begin
            hold_d[i] = '0;
            rep_d[i]  = '0;
         end else if (hold_q[i] != HOLD_DONE) begin
            hold_d[i]       = hold_q[i] + 1'b1;
            long_press_d[i] = (hold_q[i] == HOLD_LAST);
         end else if (REPEAT_CYCLES > 0) begin
            if (rep_q[i] == REP_LAST) begin
               rep_d[i]          = '0;
               repeat_pulse_d[i] = 1'b1;
            end else begin
               rep_d[i] = rep_q[i] + 1'b1;
            end
         end
      end
      any_pressed_d = |pressed_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q        <= IDLE_PIN;
         sync2_q        <= IDLE_PIN;
         stable_q       <= '0;
         pressed_q      <= '0;
         released_q     <= '0;
         long_press_q   <= '0;
         repeat_pulse_q <= '0;
         any_pressed_q  <= 1'b0;
         cnt_q          <= '{default: '0};
         hold_q         <= '{default: '0};
         rep_q          <= '{default: '0};
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         stable_q       <= stable_d;
         pressed_q      <= pressed_d;
         released_q     <= released_d;
         long_press_q   <= long_press_d;
         repeat_pulse_q <= repeat_pulse_d;
         any_pressed_q  <= any_pressed_d;
         cnt_q          <= cnt_d;
         hold_q         <= hold_d;
         rep_q          <= rep_d;
      end
   end

   assign bus.stable       = stable_q;
   assign bus.pressed      = pressed_q;
   assign bus.released     = released_q;
   assign bus.long_press   = long_press_q;
   assign bus.repeat_pulse = repeat_pulse_q;
   assign bus.any_pressed  = any_pressed_q;
endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: two instances (active-low D=2 H=10 R=3; active-high D=4 H=10 R=0).
// Expected output events are queued with their cycle; monitors pop and compare on every pulse.
module tb_debouncer_multi;
   typedef struct {
      int         cyc;
      logic [3:0] st;
      logic [3:0] pr;
      logic [3:0] rl;
      logic [3:0] lp;
      logic [3:0] rp;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_at_edge = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   ev_t  q_a[$];
   ev_t  q_b[$];
   ev_t  ev_a;
   ev_t  ev_b;

   debouncer_multi_if #(.CHANNELS(4)) if_a ();
   debouncer_multi_if #(.CHANNELS(4)) if_b ();

   debouncer_multi #(
      .CHANNELS(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(2), .CNT_WIDTH(4),
      .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .HOLD_WIDTH(16)
   ) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   debouncer_multi #(
      .CHANNELS(4), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(4),
      .HOLD_CYCLES(10), .REPEAT_CYCLES(0), .HOLD_WIDTH(16)
   ) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int which, input int c, input logic [3:0] st, input logic [3:0] pr,
                       input logic [3:0] rl, input logic [3:0] lp, input logic [3:0] rp);
      ev_t e;
      e.cyc = c;
      e.st  = st;
      e.pr  = pr;
      e.rl  = rl;
      e.lp  = lp;
      e.rp  = rp;
      if (which == 0) q_a.push_back(e);
      else            q_b.push_back(e);
   endtask

   task automatic at_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Packed as {cycle, stable, pressed, released, long_press, repeat_pulse, any_pressed}.
   always @(negedge clk) begin
      if (rst_at_edge) begin
         check("reset_a", {43'd0, if_a.stable, if_a.pressed, if_a.released,
                           if_a.long_press, if_a.repeat_pulse, if_a.any_pressed}, 64'd0);
      end else if (|{if_a.pressed, if_a.released, if_a.long_press,
                     if_a.repeat_pulse, if_a.any_pressed}) begin
         if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_a @cyc %0d: got pr=%b rl=%b lp=%b rp=%b expected no event",
                     cyc, if_a.pressed, if_a.released, if_a.long_press, if_a.repeat_pulse);
         end else begin
            ev_a = q_a.pop_front();
            check("event_a", {11'd0, 32'(cyc), if_a.stable, if_a.pressed, if_a.released,
                              if_a.long_press, if_a.repeat_pulse, if_a.any_pressed},
                  {11'd0, 32'(ev_a.cyc), ev_a.st, ev_a.pr, ev_a.rl, ev_a.lp, ev_a.rp, |ev_a.pr});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_at_edge) begin
         check("reset_b", {43'd0, if_b.stable, if_b.pressed, if_b.released,
                           if_b.long_press, if_b.repeat_pulse, if_b.any_pressed}, 64'd0);
      end else if (|{if_b.pressed, if_b.released, if_b.long_press,
                     if_b.repeat_pulse, if_b.any_pressed}) begin
         if (q_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_b @cyc %0d: got pr=%b rl=%b lp=%b rp=%b expected no event",
                     cyc, if_b.pressed, if_b.released, if_b.long_press, if_b.repeat_pulse);
         end else begin
            ev_b = q_b.pop_front();
            check("event_b", {11'd0, 32'(cyc), if_b.stable, if_b.pressed, if_b.released,
                              if_b.long_press, if_b.repeat_pulse, if_b.any_pressed},
                  {11'd0, 32'(ev_b.cyc), ev_b.st, ev_b.pr, ev_b.rl, ev_b.lp, ev_b.rp, |ev_b.pr});
         end
      end
   end

   initial begin
      if_a.btn_raw = 4'hF;
      if_b.btn_raw = 4'h0;
      rst = 1'b1;
      at_cyc(3);
      rst = 1'b0;

      // Single press and early release; pin edge at c gives the pulse at c+2+D.
      at_cyc(20);
      push(0, 24, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      push(0, 30, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      push(1, 26, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      push(1, 34, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      if_a.btn_raw[0] = 1'b0;
      if_b.btn_raw[0] = 1'b1;
      at_cyc(26);
      if_a.btn_raw[0] = 1'b1;
      at_cyc(28);
      if_b.btn_raw[0] = 1'b0;

      // Glitches: one cycle on both, three cycles (D-1) on the D=4 instance.
      at_cyc(40);
      if_a.btn_raw[1] = 1'b0;
      if_b.btn_raw[1] = 1'b1;
      at_cyc(41);
      if_a.btn_raw[1] = 1'b1;
      if_b.btn_raw[1] = 1'b0;
      at_cyc(44);
      if_b.btn_raw[1] = 1'b1;
      at_cyc(47);
      if_b.btn_raw[1] = 1'b0;

      // Long press with repeats; release lands on the cycle the next repeat was due.
      at_cyc(50);
      push(0, 54, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      push(0, 64, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
      push(0, 67, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      push(0, 70, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      push(0, 73, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      push(0, 76, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
      if_a.btn_raw[2] = 1'b0;
      at_cyc(72);
      if_a.btn_raw[2] = 1'b1;

      // Release committed one cycle before long_press would fire.
      at_cyc(90);
      push(0, 94,  4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
      push(0, 103, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
      if_a.btn_raw[3] = 1'b0;
      at_cyc(99);
      if_a.btn_raw[3] = 1'b1;

      // All channels together, staggered releases.
      at_cyc(110);
      push(0, 114, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      push(0, 120, 4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
      push(0, 121, 4'b1100, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
      push(0, 123, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000);
      if_a.btn_raw = 4'b0000;
      at_cyc(116);
      if_a.btn_raw[0] = 1'b1;
      at_cyc(117);
      if_a.btn_raw[1] = 1'b1;
      at_cyc(119);
      if_a.btn_raw[3:2] = 2'b11;

      // Reset mid-hold (ch0) and mid-debounce (ch1), buttons held throughout.
      at_cyc(130);
      push(0, 134, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      push(0, 145, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
      push(0, 154, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
      push(1, 136, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      push(1, 147, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
      push(1, 156, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 4'b0000);
      if_a.btn_raw[0] = 1'b0;
      if_b.btn_raw[0] = 1'b1;
      at_cyc(136);
      if_a.btn_raw[1] = 1'b0;
      if_b.btn_raw[1] = 1'b1;
      at_cyc(138);
      rst = 1'b1;
      at_cyc(141);
      rst = 1'b0;
      at_cyc(150);
      if_a.btn_raw[1:0] = 2'b11;
      if_b.btn_raw[1:0] = 2'b00;

      // Repeat disabled: a ~200-cycle hold yields exactly one long_press.
      at_cyc(160);
      push(1, 166, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      push(1, 176, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
      push(1, 376, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
      if_b.btn_raw[2] = 1'b1;
      at_cyc(370);
      if_b.btn_raw[2] = 1'b0;

      at_cyc(400);
      check("drain_a", 64'(q_a.size()), 64'd0);
      check("drain_b", 64'(q_b.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
